// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM loader and its lane array.
package bootram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    VERIFY,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_LEN    = 2'd1;
  localparam logic [1:0] ERR_CSUM   = 2'd2;
  localparam logic [1:0] ERR_VERIFY = 2'd3;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

  // Mod-256 sum of the four byte lanes of one read-back word.
  function automatic logic [7:0] byte_sum4(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

endpackage

// File: rtl/bootram_2kx8.sv
// Single-port 2Kx8 boot RAM lane with a registered read port (1-cycle latency).
module bootram_2kx8 #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [7:0]        din,
  output logic [7:0]        dout
);

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] dout_q;

  always_ff @(posedge clk) begin
    if (ce && wre) begin
      mem[ad] <= din;
    end
    if (ce && oce && !wre) begin
      dout_q <= mem[ad];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/bootram_lane_array.sv
// Four byte lanes forming one 32-bit word per address; lane k owns bits [8k+7:8k].
module bootram_lane_array #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              ram_ce,
  input  logic              ram_oce,
  input  logic              ram_wre,
  input  logic [3:0]        ram_be,
  input  logic [ADDR_W-1:0] ram_ad,
  input  logic [7:0]        ram_din,
  output logic [31:0]       ram_dout
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    bootram_2kx8 #(
      .ADDR_W(ADDR_W)
    ) u_lane (
      .clk  (clk),
      .ce   (ram_ce),
      .oce  (ram_oce),
      .wre  (ram_wre & ram_be[k]),
      .ad   (ram_ad),
      .din  (ram_din),
      .dout (ram_dout[8*k +: 8])
    );
  end

endmodule

// File: rtl/bootram_loader.sv
// Loads a framed byte stream into the boot RAM lanes, optionally reads it back
// to check it, and holds the CPU in reset until the image is good.
module bootram_loader
  import bootram_pkg::*;
#(
  parameter int         ADDR_W    = 11,
  parameter logic [7:0] MAGIC     = BOOT_MAGIC,
  parameter bit         VERIFY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              restart,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [31:0]       ram_dout,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err
);

  localparam int          CNT_W = ADDR_W + 2;
  localparam int          RD_W  = ADDR_W + 1;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        vsum_q, vsum_d;
  logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [RD_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ram_ce_q, ram_ce_d;
  logic              ram_wre_q, ram_wre_d;
  logic [3:0]        ram_be_q, ram_be_d;
  logic [ADDR_W-1:0] ram_ad_q, ram_ad_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              s_ready_q, s_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic              fire;
  logic [15:0]       len_new;
  logic [CNT_W-1:0]  last_idx;
  logic [RD_W-1:0]   len_words;
  logic              len_zero;

  assign fire      = s_valid & s_ready_q;
  assign len_new   = {s_data, len_q[7:0]};
  assign len_words = len_q[RD_W-1:0];
  assign len_zero  = (len_q == 16'd0);
  // Index of the last payload byte, 4*LEN-1; for LEN == DEPTH the low bits
  // are zero and the decrement wraps to all-ones, which is exactly right.
  assign last_idx  = {len_q[ADDR_W-1:0] - ADDR_W'(1), 2'b11};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    csum_d     = csum_q;
    vsum_d     = vsum_q;
    rd_cnt_d   = rd_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    rd_valid_d = ram_ce_q & ~ram_wre_q;
    ram_ce_d   = 1'b0;
    ram_wre_d  = 1'b0;
    ram_be_d   = 4'b0000;
    ram_ad_d   = ram_ad_q;
    ram_din_d  = ram_din_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (fire && s_data == MAGIC) begin
          state_d = LEN0;
        end
      end
      LEN0: begin
        if (fire) begin
          len_d   = {8'h00, s_data};
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (fire) begin
          len_d = len_new;
          cnt_d = '0;
          sum_d = 8'h00;
          if ({1'b0, len_new} > DEPTH) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else if (len_new == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (fire) begin
          ram_ce_d  = 1'b1;
          ram_wre_d = 1'b1;
          ram_be_d  = 4'b0001 << cnt_q[1:0];
          ram_ad_d  = cnt_q[CNT_W-1:2];
          ram_din_d = s_data;
          sum_d     = sum_q + s_data;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == last_idx) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (fire) begin
          csum_d = s_data;
          if (s_data != sum_q) begin
            state_d = ERROR;
            err_d   = ERR_CSUM;
          end else if (!VERIFY_EN) begin
            state_d = DONE;
          end else begin
            // The first read is launched here so VERIFY spends exactly LEN+2 cycles.
            state_d   = VERIFY;
            vsum_d    = 8'h00;
            cap_cnt_d = '0;
            rd_cnt_d  = '0;
            if (!len_zero) begin
              ram_ce_d = 1'b1;
              ram_ad_d = '0;
              rd_cnt_d = RD_W'(1);
            end
          end
        end
      end
      VERIFY: begin
        if (rd_cnt_q != len_words) begin
          ram_ce_d = 1'b1;
          ram_ad_d = rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d = rd_cnt_q + RD_W'(1);
        end
        if (rd_valid_q) begin
          vsum_d    = vsum_q + byte_sum4(ram_dout);
          cap_cnt_d = cap_cnt_q + RD_W'(1);
        end
        if (cap_cnt_q == len_words) begin
          if (vsum_q == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = ERR_VERIFY;
          end
        end
      end
      DONE, ERROR: begin
        if (restart) begin
          state_d = IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d  = (state_d == IDLE) || (state_d == LEN0) || (state_d == LEN1) ||
                 (state_d == DATA) || (state_d == CSUM);
    done_d     = (state_d == DONE);
    cpu_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      cnt_q      <= '0;
      sum_q      <= 8'h00;
      csum_q     <= 8'h00;
      vsum_q     <= 8'h00;
      rd_cnt_q   <= '0;
      cap_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      ram_ce_q   <= 1'b0;
      ram_wre_q  <= 1'b0;
      ram_be_q   <= 4'b0000;
      ram_ad_q   <= '0;
      ram_din_q  <= 8'h00;
      s_ready_q  <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      csum_q     <= csum_d;
      vsum_q     <= vsum_d;
      rd_cnt_q   <= rd_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      rd_valid_q <= rd_valid_d;
      ram_ce_q   <= ram_ce_d;
      ram_wre_q  <= ram_wre_d;
      ram_be_q   <= ram_be_d;
      ram_ad_q   <= ram_ad_d;
      ram_din_q  <= ram_din_d;
      s_ready_q  <= s_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign ram_ce   = ram_ce_q;
  assign ram_oce  = ram_ce_q;
  assign ram_wre  = ram_wre_q;
  assign ram_be   = ram_be_q;
  assign ram_ad   = ram_ad_q;
  assign ram_din  = ram_din_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
